// File: rtl/multi_channel_fft_scheduler.sv
// Round-robin front end that shares one FFT core across NUM_CH ADC FIFOs, streams one
// DC-corrected real frame per grant over AXI4-Stream and tags the returning magnitudes.
module multi_channel_fft_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int FFT_POINTS  = 8192,
    parameter int ADDR_W      = 13,
    parameter int ADC_BITS    = 10,
    parameter int LVL_W       = 14,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [1:0]                  dc_mode,
    input  logic [NUM_CH*LVL_W-1:0]     fifo_level,
    input  logic [NUM_CH*16-1:0]        fifo_dout,
    output logic [NUM_CH-1:0]           fifo_rd_en,
    output logic [31:0]                 fft_din,
    output logic                        fft_din_valid,
    output logic                        fft_din_last,
    input  logic                        fft_din_ready,
    input  logic                        fft_dout_valid,
    input  logic                        fft_dout_last,
    input  logic [15:0]                 mag_data,
    input  logic [ADDR_W-1:0]           mag_addr,
    input  logic                        mag_valid,
    output logic [15:0]                 spec_data,
    output logic [ADDR_W-1:0]           spec_addr,
    output logic [$clog2(NUM_CH)-1:0]   spec_ch,
    output logic                        spec_valid,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout_err
);

    localparam int CW = $clog2(NUM_CH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = ADC_BITS + ADDR_W;
    localparam logic [ADC_BITS-1:0] MID = {1'b1, {(ADC_BITS-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_RECV  = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       last_ch;
    logic [1:0]          frame_mode;
    logic [ADDR_W:0]     rd_cnt;
    logic [ADDR_W-1:0]   beat_cnt;
    logic [1:0]          skid_cnt;
    logic                pend;
    logic [15:0]         q0, q1;
    logic [SW-1:0]       sum;
    logic [ADC_BITS-1:0] mean [NUM_CH];
    logic [TW-1:0]       tcnt;

    logic [NUM_CH-1:0]   elig;
    logic                grant_ok;
    logic [CW-1:0]       grant_ch;
    logic [CW:0]         scan;
    logic [15:0]         word;
    logic [ADC_BITS-1:0] s, off;
    logic [ADC_BITS:0]   diff;
    logic [15:0]         sample_real;
    logic [2:0]          occ;
    logic                pop, rd_go, frame_end;

    always_comb begin
        elig = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            elig[c] = ch_en[c] && (32'(fifo_level[c*LVL_W +: LVL_W]) >= 32'(FFT_POINTS));
    end

    // First eligible channel scanning upward from the one after the last grant.
    always_comb begin
        grant_ok = 1'b0;
        grant_ch = '0;
        scan     = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            scan = {1'b0, last_ch} + (CW+1)'(i);
            if (scan >= (CW+1)'(NUM_CH))
                scan = scan - (CW+1)'(NUM_CH);
            if (!grant_ok && elig[scan[CW-1:0]]) begin
                grant_ok = 1'b1;
                grant_ch = scan[CW-1:0];
            end
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (cur_ch == CW'(c))
                word = fifo_dout[c*16 +: 16];
    end

    assign s           = word[15 -: ADC_BITS];
    assign off         = (frame_mode == 2'd0) ? '0 : (frame_mode == 2'd2) ? mean[cur_ch] : MID;
    assign diff        = {1'b0, s} - {1'b0, off};
    assign sample_real = {{(15-ADC_BITS){diff[ADC_BITS]}}, diff};

    assign fft_din_valid = (state == S_SEND) && (skid_cnt != 2'd0);
    assign fft_din_last  = fft_din_valid && (beat_cnt == ADDR_W'(FFT_POINTS - 1));
    assign fft_din       = {16'd0, q0};
    assign pop           = fft_din_valid && fft_din_ready;

    // A read issued now lands a cycle later; reserve its slot against worst-case no-pop.
    assign occ   = 3'(skid_cnt) + 3'(pend) - 3'(pop);
    assign rd_go = ((state == S_PRIME) || (state == S_SEND)) &&
                   (rd_cnt < (ADDR_W+1)'(FFT_POINTS)) && (occ <= 3'd1);

    always_comb begin
        fifo_rd_en = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            fifo_rd_en[c] = rd_go && (cur_ch == CW'(c));
    end

    assign frame_end   = (state == S_RECV) && fft_dout_valid && fft_dout_last;
    assign frame_done  = frame_end;
    assign timeout_err = (state == S_RECV) && !frame_end && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_ch    <= CW'(NUM_CH - 1);
            cur_ch     <= '0;
            frame_mode <= '0;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
            skid_cnt   <= '0;
            pend       <= 1'b0;
            q0         <= '0;
            q1         <= '0;
            sum        <= '0;
            tcnt       <= '0;
            spec_valid <= 1'b0;
            spec_data  <= '0;
            spec_addr  <= '0;
            spec_ch    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++)
                mean[c] <= MID;
        end else begin
            pend       <= rd_go;
            spec_valid <= 1'b0;
            if (rd_go)
                rd_cnt <= rd_cnt + 1'b1;
            if (pend)
                sum <= sum + SW'(s);
            if (pop)
                beat_cnt <= beat_cnt + 1'b1;

            case ({pend, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) q0 <= sample_real;
                    else                  q1 <= sample_real;
                    skid_cnt <= skid_cnt + 1'b1;
                end
                2'b01: begin
                    q0       <= q1;
                    skid_cnt <= skid_cnt - 1'b1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        q0 <= sample_real;
                    end else begin
                        q0 <= q1;
                        q1 <= sample_real;
                    end
                end
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        state      <= S_PRIME;
                        cur_ch     <= grant_ch;
                        last_ch    <= grant_ch;
                        frame_mode <= dc_mode;
                        rd_cnt     <= '0;
                        beat_cnt   <= '0;
                        skid_cnt   <= '0;
                        sum        <= '0;
                    end
                end
                S_PRIME: state <= S_SEND;
                S_SEND: begin
                    if (pop && fft_din_last) begin
                        state        <= S_RECV;
                        tcnt         <= '0;
                        mean[cur_ch] <= sum[SW-1:ADDR_W];
                    end
                end
                default: begin
                    tcnt <= tcnt + 1'b1;
                    if (mag_valid) begin
                        spec_valid <= 1'b1;
                        spec_data  <= mag_data;
                        spec_addr  <= mag_addr;
                        spec_ch    <= cur_ch;
                    end
                    if (frame_end || timeout_err)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_fft_scheduler.sv
// Randomised bench for multi_channel_fft_scheduler: FIFO model feeds frames, a reference
// model predicts grants, DC-corrected samples, running means and RECV-phase behaviour.
module tb_multi_channel_fft_scheduler;

    localparam int NCH = 4;
    localparam int PTS = 16;
    localparam int AW  = 4;
    localparam int AB  = 10;
    localparam int LW  = 14;
    localparam int TO  = 100;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    ch_en;
    logic [1:0]        dc_mode;
    logic [NCH*LW-1:0] fifo_level;
    logic [NCH*16-1:0] fifo_dout = '0;
    logic [NCH-1:0]    fifo_rd_en;
    logic [31:0]       fft_din;
    logic              fft_din_valid, fft_din_last, fft_din_ready;
    logic              fft_dout_valid, fft_dout_last;
    logic [15:0]       mag_data;
    logic [AW-1:0]     mag_addr;
    logic              mag_valid;
    logic [15:0]       spec_data;
    logic [AW-1:0]     spec_addr;
    logic [1:0]        spec_ch;
    logic              spec_valid;
    logic [1:0]        cur_ch;
    logic              busy, frame_done, timeout_err;

    logic [LW-1:0]     lvl [NCH];
    assign fifo_level = {lvl[3], lvl[2], lvl[1], lvl[0]};

    multi_channel_fft_scheduler #(
        .NUM_CH(NCH), .FFT_POINTS(PTS), .ADDR_W(AW), .ADC_BITS(AB), .LVL_W(LW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .dc_mode(dc_mode),
        .fifo_level(fifo_level), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .fft_din(fft_din), .fft_din_valid(fft_din_valid), .fft_din_last(fft_din_last),
        .fft_din_ready(fft_din_ready), .fft_dout_valid(fft_dout_valid), .fft_dout_last(fft_dout_last),
        .mag_data(mag_data), .mag_addr(mag_addr), .mag_valid(mag_valid),
        .spec_data(spec_data), .spec_addr(spec_addr), .spec_ch(spec_ch), .spec_valid(spec_valid),
        .cur_ch(cur_ch), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: read latency 1, per-channel circular store
    logic [15:0] mem [NCH][64];
    int wr_ptr   [NCH] = '{default: 0};
    int rd_ptr   [NCH] = '{default: 0};
    int rd_count [NCH] = '{default: 0};
    int underflow = 0;
    int multi_rd  = 0;

    always @(posedge clk) begin
        if ($countones(fifo_rd_en) > 1)
            multi_rd <= multi_rd + 1;
        for (int c = 0; c < NCH; c++) begin
            if (fifo_rd_en[c]) begin
                rd_count[c] <= rd_count[c] + 1;
                if (rd_ptr[c] == wr_ptr[c]) begin
                    underflow <= underflow + 1;
                end else begin
                    fifo_dout[c*16 +: 16] <= mem[c][rd_ptr[c] % 64];
                    rd_ptr[c] <= rd_ptr[c] + 1;
                end
            end
        end
    end

    // Reference model state
    int mean_m [NCH] = '{default: 512};
    int last_m = NCH - 1;

    function automatic int pick_ch();
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c = (last_m + i) % NCH;
            if (ch_en[c] && int'(lvl[c]) >= PTS)
                return c;
        end
        return -1;
    endfunction

    // kind: 0 random, 1 ramp k<<6, 2 constant 600<<6
    task automatic run_frame(input int kind, input int mode, input int stall_pct,
                             input bit do_mag, input bit do_timeout, input bit clr_en);
        int ch, k, cyc, w, total, sum, n, nspec;
        int rb [NCH];
        logic [15:0] words [PTS];
        logic [15:0] exp_r [PTS];
        logic [31:0] prev_din;
        logic [15:0] pd;
        logic [AW-1:0] pa;
        bit prev_stall, pend_m;

        ch = pick_ch();
        if (ch < 0) begin
            $display("FAIL arb: no eligible channel predicted");
            $fatal(1);
        end
        sum = 0;
        for (int i = 0; i < PTS; i++) begin
            int sv, off;
            case (kind)
                1:       words[i] = 16'(i << 6);
                2:       words[i] = 16'(600 << 6);
                default: words[i] = 16'($urandom);
            endcase
            mem[ch][wr_ptr[ch] % 64] = words[i];
            wr_ptr[ch]++;
            sv  = int'(words[i] >> 6);
            off = (mode == 0) ? 0 : (mode == 2) ? mean_m[ch] : 512;
            exp_r[i] = 16'(sv - off);
            sum += sv;
        end
        for (int c = 0; c < NCH; c++) rb[c] = rd_count[c];
        dc_mode = 2'(mode);

        w = 0;
        while (!busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("grant_busy", 32'(busy), 32'd1);
        check_eq("grant_ch", 32'(cur_ch), 32'(ch));
        last_m = ch;
        dc_mode = 2'($urandom);
        if (clr_en) ch_en[ch] = 1'b0;

        k = 0; cyc = 0; prev_stall = 0; prev_din = '0;
        while (k < PTS && cyc < 400) begin
            fft_din_ready = ($urandom_range(99) >= stall_pct);
            if (prev_stall) begin
                check_eq("hold_valid", 32'(fft_din_valid), 32'd1);
                check_eq("hold_data", fft_din, prev_din);
            end
            if (fft_din_valid && fft_din_ready) begin
                check_eq("beat_data", fft_din, {16'd0, exp_r[k]});
                check_eq("beat_last", 32'(fft_din_last), 32'(k == PTS - 1));
                k++;
            end
            prev_stall = fft_din_valid && !fft_din_ready;
            prev_din   = fft_din;
            @(negedge clk);
            cyc++;
        end
        fft_din_ready = 1'b0;
        check_eq("beats", 32'(k), 32'(PTS));
        check_eq("recv_valid", 32'(fft_din_valid), 32'd0);
        check_eq("recv_busy", 32'(busy), 32'd1);
        total = 0;
        for (int c = 0; c < NCH; c++) total += rd_count[c] - rb[c];
        check_eq("rd_ch", 32'(rd_count[ch] - rb[ch]), 32'(PTS));
        check_eq("rd_total", 32'(total), 32'(PTS));
        mean_m[ch] = sum / PTS;

        if (do_timeout) begin
            for (int j = 1; j <= TO + 1; j++) begin
                check_eq("to_fdone", 32'(frame_done), 32'd0);
                if (j <= TO) begin
                    check_eq("to_err", 32'(timeout_err), 32'(j == TO));
                    check_eq("to_busy", 32'(busy), 32'd1);
                end else begin
                    check_eq("to_idle", 32'(busy), 32'd0);
                end
                if (j <= TO) @(negedge clk);
            end
        end else begin
            n = do_mag ? PTS : int'($urandom_range(4));
            pend_m = 0; pd = '0; pa = '0; nspec = 0;
            for (int i = 0; i <= n; i++) begin
                check_eq("spec_valid", 32'(spec_valid), 32'(pend_m));
                if (spec_valid) nspec++;
                if (pend_m) begin
                    check_eq("spec_data", 32'(spec_data), 32'(pd));
                    check_eq("spec_addr", 32'(spec_addr), 32'(pa));
                    check_eq("spec_ch", 32'(spec_ch), 32'(ch));
                end
                pend_m = do_mag && (i < n);
                mag_valid = pend_m;
                pd = 16'($urandom); pa = AW'(i);
                mag_data = pd; mag_addr = pa;
                fft_dout_valid = 1'($urandom_range(1));
                fft_dout_last  = 1'b0;
                #1;
                check_eq("early_fdone", 32'(frame_done), 32'd0);
                @(negedge clk);
            end
            mag_valid = 1'b0;
            if (do_mag) check_eq("spec_count", 32'(nspec), 32'(PTS));
            fft_dout_valid = 1'b1;
            fft_dout_last  = 1'b1;
            #1;
            check_eq("frame_done", 32'(frame_done), 32'd1);
            check_eq("fd_no_to", 32'(timeout_err), 32'd0);
            @(negedge clk);
            fft_dout_valid = 1'b0;
            fft_dout_last  = 1'b0;
            check_eq("end_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ch_en = '0; dc_mode = '0;
        for (int c = 0; c < NCH; c++) lvl[c] = '0;
        fft_din_ready = 1'b0; fft_dout_valid = 1'b0; fft_dout_last = 1'b0;
        mag_data = '0; mag_addr = '0; mag_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst_din", fft_din, 32'd0);
        check_eq("rst_valid", 32'(fft_din_valid), 32'd0);
        check_eq("rst_last", 32'(fft_din_last), 32'd0);
        check_eq("rst_spec", 32'({spec_valid, spec_data, spec_addr, spec_ch}), 32'd0);
        check_eq("rst_cur_ch", 32'(cur_ch), 32'd0);
        check_eq("rst_flags", 32'({busy, frame_done, timeout_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_none", 32'(busy), 32'd0);

        // ch2 one below the threshold, ch0 well below: only ch1/ch3 eligible
        lvl[0] = 14'd7; lvl[1] = 14'd16; lvl[2] = 14'd15; lvl[3] = 14'd16;
        ch_en = 4'hF;
        run_frame(1, 1, 0, 0, 0, 0);
        run_frame(0, int'($urandom_range(3)), 50, 0, 0, 0);
        run_frame(0, 2, 50, 0, 0, 0);
        run_frame(0, 3, 30, 0, 0, 1);
        run_frame(0, 0, 50, 0, 0, 0);
        run_frame(0, 1, 50, 0, 0, 0);

        ch_en = 4'b0001; lvl[0] = 14'd16;
        run_frame(2, 2, 0, 0, 0, 0);
        run_frame(2, 2, 50, 0, 0, 0);

        ch_en = 4'b0100; lvl[2] = 14'd16;
        run_frame(0, 0, 20, 1, 0, 0);
        ch_en = '0;

        for (int i = 0; i < 8; i++) begin
            mag_valid = 1'($urandom_range(1));
            mag_data  = 16'($urandom);
            @(negedge clk);
            check_eq("idle_spec", 32'(spec_valid), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
        end
        mag_valid = 1'b0;

        ch_en = 4'b0001;
        run_frame(0, 1, 0, 0, 1, 0);
        ch_en = '0;

        repeat (2) @(negedge clk);
        check_eq("underflow", 32'(underflow), 32'd0);
        check_eq("multi_rd", 32'(multi_rd), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
